// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//   Bundle of signals between the hazard unit / upstream stage, one
//   pipe_stage_reg instance and the downstream stage.
//
//   Handshake: there is no ready/backpressure. out_valid qualifies out_data
//   on every cycle it is high; upstream holds a word by asserting stall,
//   which freezes the register contents; flush turns the contents into a bubble.
//
//   Signals
//     in_valid   upstream word is a real instruction
//     in_data    LANES*DATA_W payload, lane k = in_data[k*DATA_W +: DATA_W]
//     stall      hold current contents
//     flush      request bubble
//     out_valid  latched valid bit
//     out_data   latched payload
//     flush_pend deferred flush armed
//     stall_cnt  saturating count of held cycles with out_valid=1
//     flush_cnt  saturating count of applied clears
//
//   Modports
//     master  drives the inputs, observes the outputs (hazard unit / bench)
//     slave   the pipeline register itself
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int CNT_W  = 16
) ();
  logic                    in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    stall;
  logic                    flush;
  logic                    out_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    flush_pend;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output in_valid, in_data, stall, flush,
    input  out_valid, out_data, flush_pend, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output out_valid, out_data, flush_pend, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying LANES
//   payload words plus a valid bit. Supports stall (hold), flush (bubble)
//   applied either on the same edge or one edge later, and saturating
//   stall/flush event counters for performance monitoring.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pipe_stage_reg_if.slave: in_valid, in_data, stall, flush in;
//            out_valid, out_data, flush_pend, stall_cnt, flush_cnt out
//
//   Per-edge priority: clear > stall > load. All outputs are flop outputs,
//   there is no combinational path from any input to any output.
//   This block has no FSM; its entire state is visible on the outputs.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W        = 32,
  parameter int                LANES         = 2,
  parameter int                FLUSH_DELAYED = 1,
  parameter logic [DATA_W-1:0] CLR_VAL       = '0,
  parameter int                CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_stage_reg_if.slave bus
);

  localparam int                PW      = LANES * DATA_W;
  localparam logic [PW-1:0]     CLR_VEC = {LANES{CLR_VAL}};
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit                DEFER   = (FLUSH_DELAYED != 0);

  logic             r_valid;
  logic [PW-1:0]    r_data;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_clr;

  // In deferred mode the clear acts on the flush seen one edge earlier;
  // in immediate mode the pending flop stays at 0 and flush acts directly.
  assign w_clr = DEFER ? r_flush_pend : bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= CLR_VEC;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      // Tracks flush every edge, independent of stall.
      r_flush_pend <= DEFER ? bus.flush : 1'b0;

      if (w_clr) begin
        r_valid <= 1'b0;
        r_data  <= CLR_VEC;
        if (r_flush_cnt != CNT_MAX) begin
          r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
      end else if (bus.stall) begin
        // Holding a bubble is not a real stall and is not counted.
        if (r_valid && (r_stall_cnt != CNT_MAX)) begin
          r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
      end else begin
        // Payload is loaded even for invalid words; out_valid qualifies it.
        r_valid <= bus.in_valid;
        r_data  <= bus.in_data;
      end
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_data   = r_data;
  assign bus.flush_pend = r_flush_pend;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Three instances: u_dut_d (deferred flush, CLR_VAL=0, CNT_W=16),
//   u_dut_i (immediate flush, non-zero CLR_VAL) and u_dut_s (CNT_W=3).
//   Inputs are driven 1 time unit after the rising edge, outputs are
//   checked 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DW    = 32;
  localparam int          LN    = 2;
  localparam int          W     = 1 + LN * DW;
  localparam logic [31:0] CLR_I = 32'hA5A5_0F0F;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN), .CNT_W(16)) bus_d ();
  pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN), .CNT_W(16)) bus_i ();
  pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN), .CNT_W(3))  bus_s ();

  pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .FLUSH_DELAYED(1), .CLR_VAL(32'h0), .CNT_W(16))
    u_dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));
  pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .FLUSH_DELAYED(0), .CLR_VAL(CLR_I), .CNT_W(16))
    u_dut_i (.clk(clk), .rst_n(rst_n), .bus(bus_i));
  pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .FLUSH_DELAYED(1), .CLR_VAL(32'h0), .CNT_W(3))
    u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_d(input logic v, input logic [31:0] l0, input logic [31:0] l1,
                       input logic s, input logic f);
    bus_d.in_valid = v;
    bus_d.in_data  = {l1, l0};
    bus_d.stall    = s;
    bus_d.flush    = f;
  endtask

  task automatic set_i(input logic v, input logic [31:0] l0, input logic [31:0] l1,
                       input logic s, input logic f);
    bus_i.in_valid = v;
    bus_i.in_data  = {l1, l0};
    bus_i.stall    = s;
    bus_i.flush    = f;
  endtask

  task automatic set_s(input logic v, input logic [31:0] l0, input logic [31:0] l1,
                       input logic s, input logic f);
    bus_s.in_valid = v;
    bus_s.in_data  = {l1, l0};
    bus_s.stall    = s;
    bus_s.flush    = f;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        vld;
    logic [31:0] l0;
    logic [31:0] l1;
    logic        stall;
    logic        flush;
    logic        e_vld;
    logic [31:0] e_l0;
    logic [31:0] e_l1;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
    logic        e_pend;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  initial begin
    logic [W-1:0] exp_w;
    logic [2:0]   exp_sc;

    // Pass-through, stall, bubble-stall, deferred flush (expected values after the edge)
    vt[0]  = '{1'b1, 32'h04, 32'h8C01_0000, 1'b0, 1'b0, 1'b1, 32'h04, 32'h8C01_0000, 16'd0, 16'd0, 1'b0};
    vt[1]  = '{1'b1, 32'h10, 32'hA1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hA1, 16'd0, 16'd0, 1'b0};
    vt[2]  = '{1'b1, 32'h14, 32'hA2, 1'b0, 1'b0, 1'b1, 32'h14, 32'hA2, 16'd0, 16'd0, 1'b0};
    vt[3]  = '{1'b1, 32'h18, 32'hA3, 1'b0, 1'b0, 1'b1, 32'h18, 32'hA3, 16'd0, 16'd0, 1'b0};
    vt[4]  = '{1'b1, 32'h1C, 32'hA4, 1'b0, 1'b0, 1'b1, 32'h1C, 32'hA4, 16'd0, 16'd0, 1'b0};
    vt[5]  = '{1'b1, 32'h99, 32'h99, 1'b1, 1'b0, 1'b1, 32'h1C, 32'hA4, 16'd1, 16'd0, 1'b0};
    vt[6]  = '{1'b1, 32'h99, 32'h99, 1'b1, 1'b0, 1'b1, 32'h1C, 32'hA4, 16'd2, 16'd0, 1'b0};
    vt[7]  = '{1'b1, 32'h99, 32'h99, 1'b1, 1'b0, 1'b1, 32'h1C, 32'hA4, 16'd3, 16'd0, 1'b0};
    vt[8]  = '{1'b0, 32'h20, 32'hB0, 1'b0, 1'b0, 1'b0, 32'h20, 32'hB0, 16'd3, 16'd0, 1'b0};
    vt[9]  = '{1'b1, 32'h77, 32'h77, 1'b1, 1'b0, 1'b0, 32'h20, 32'hB0, 16'd3, 16'd0, 1'b0};
    vt[10] = '{1'b1, 32'h77, 32'h77, 1'b1, 1'b0, 1'b0, 32'h20, 32'hB0, 16'd3, 16'd0, 1'b0};
    vt[11] = '{1'b1, 32'h77, 32'h77, 1'b1, 1'b0, 1'b0, 32'h20, 32'hB0, 16'd3, 16'd0, 1'b0};
    vt[12] = '{1'b1, 32'h24, 32'hC0, 1'b0, 1'b0, 1'b1, 32'h24, 32'hC0, 16'd3, 16'd0, 1'b0};
    vt[13] = '{1'b1, 32'h55, 32'h55, 1'b1, 1'b1, 1'b1, 32'h24, 32'hC0, 16'd4, 16'd0, 1'b1};
    vt[14] = '{1'b1, 32'h55, 32'h55, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00, 16'd4, 16'd1, 1'b0};
    vt[15] = '{1'b1, 32'h28, 32'hD0, 1'b0, 1'b1, 1'b1, 32'h28, 32'hD0, 16'd4, 16'd1, 1'b1};
    vt[16] = '{1'b1, 32'h2C, 32'hD1, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 16'd4, 16'd2, 1'b1};
    vt[17] = '{1'b1, 32'h30, 32'hD2, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 16'd4, 16'd3, 1'b0};
    vt[18] = '{1'b1, 32'h34, 32'hD3, 1'b0, 1'b0, 1'b1, 32'h34, 32'hD3, 16'd4, 16'd3, 1'b0};

    set_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_i(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_s(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // ---------------- reset behaviour ----------------
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("init_valid", bus_d.out_valid, 1'b0);

    set_d(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    chk("pre_rst_load", {bus_d.out_valid, bus_d.out_data}, {1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    set_d(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick();
    chk("pre_rst_stall_cnt", bus_d.stall_cnt, 16'd1);
    set_d(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    tick();
    chk("pre_rst_pend", bus_d.flush_pend, 1'b1);

    // Mid-cycle asynchronous reset, no clock edge in between
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus_d.out_valid, 1'b0);
    chk("async_rst_data", bus_d.out_data, 64'h0);
    chk("async_rst_stall_cnt", bus_d.stall_cnt, 16'd0);
    chk("async_rst_flush_cnt", bus_d.flush_cnt, 16'd0);
    chk("async_rst_pend", bus_d.flush_pend, 1'b0);

    // Flush held across an edge while in reset: reset wins
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_pend", bus_d.flush_pend, 1'b0);
    set_d(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    chk("rel_no_clear_cnt", bus_d.flush_cnt, 16'd0);
    chk("rel_pend_after_edge", bus_d.flush_pend, 1'b0);

    // ---------------- table-driven sequence on deferred-flush instance ----------------
    for (int i = 0; i < NV; i++) begin
      set_d(vt[i].vld, vt[i].l0, vt[i].l1, vt[i].stall, vt[i].flush);
      exp_q.push_back({vt[i].e_vld, vt[i].e_l1, vt[i].e_l0});
      tick();
      exp_w = exp_q.pop_front();
      chk($sformatf("vec%0d_out", i), {bus_d.out_valid, bus_d.out_data}, exp_w);
      chk($sformatf("vec%0d_stall_cnt", i), bus_d.stall_cnt, vt[i].e_sc);
      chk($sformatf("vec%0d_flush_cnt", i), bus_d.flush_cnt, vt[i].e_fc);
      chk($sformatf("vec%0d_pend", i), bus_d.flush_pend, vt[i].e_pend);
    end
    set_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // ---------------- immediate-flush instance ----------------
    set_i(1'b1, 32'h40, 32'hE0, 1'b0, 1'b0);
    tick();
    chk("imm_load", {bus_i.out_valid, bus_i.out_data}, {1'b1, 32'hE0, 32'h40});
    set_i(1'b1, 32'h44, 32'hE1, 1'b0, 1'b1);
    tick();
    chk("imm_flush_out", {bus_i.out_valid, bus_i.out_data}, {1'b0, CLR_I, CLR_I});
    chk("imm_flush_pend", bus_i.flush_pend, 1'b0);
    chk("imm_flush_cnt", bus_i.flush_cnt, 16'd1);
    set_i(1'b1, 32'h48, 32'hE2, 1'b0, 1'b0);
    tick();
    chk("imm_reload", {bus_i.out_valid, bus_i.out_data}, {1'b1, 32'hE2, 32'h48});
    chk("imm_reload_cnt", bus_i.flush_cnt, 16'd1);
    set_i(1'b1, 32'h4C, 32'hE3, 1'b1, 1'b1);
    tick();
    chk("imm_flush_stall_out", {bus_i.out_valid, bus_i.out_data}, {1'b0, CLR_I, CLR_I});
    chk("imm_flush_stall_fcnt", bus_i.flush_cnt, 16'd2);
    chk("imm_flush_stall_scnt", bus_i.stall_cnt, 16'd0);
    chk("imm_flush_stall_pend", bus_i.flush_pend, 1'b0);
    set_i(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // ---------------- saturation with CNT_W=3 ----------------
    set_s(1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
    tick();
    chk("sat_load", {bus_s.out_valid, bus_s.out_data}, {1'b1, 32'h2, 32'h1});
    for (int k = 1; k <= 10; k++) begin
      set_s(1'b1, 32'h5, 32'h6, 1'b1, 1'b0);
      tick();
      exp_sc = (k < 7) ? 3'(k) : 3'd7;
      chk($sformatf("sat_stall_cnt_%0d", k), bus_s.stall_cnt, exp_sc);
    end
    chk("sat_data_held", {bus_s.out_valid, bus_s.out_data}, {1'b1, 32'h2, 32'h1});
    set_s(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: actual=%0d required=0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
